stopwatch_core: RTL and testbench

Timekeeping stage of the stopwatch display path. Turns debounced start/stop, lap and clear button levels into a running MM:SS.CC count, packed as six BCD digits. Its output feeds the 6-digit multiplexed seven-segment display controller directly. Owns the run/pause/lap state machine, the 100 Hz tick prescaler and the cascaded BCD counters.

---
 rtl/stopwatch_pkg.sv | 26 ++
 rtl/bcd_digit_counter.sv | 33 +++
 rtl/stopwatch_core.sv | 204 ++++++++++++++++++++
 tb/tb_stopwatch_core.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch timekeeping stage.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUNNING  = 2'd1,
        ST_PAUSED   = 2'd2,
        ST_LAP_HOLD = 2'd3
    } state_t;

    localparam logic [3:0] DIGIT_MAX_9 = 4'd9;
    localparam logic [3:0] DIGIT_MAX_5 = 4'd5;

    // Nibble positions inside the packed MM:SS.CC display word
    localparam int CS_ONES_LSB  = 0;
    localparam int CS_TENS_LSB  = 4;
    localparam int SEC_ONES_LSB = 8;
    localparam int SEC_TENS_LSB = 12;
    localparam int MIN_ONES_LSB = 16;
    localparam int MIN_TENS_LSB = 20;

    function automatic int tick_div(input int clk_freq_hz, input int tick_hz);
        return clk_freq_hz / tick_hz;
    endfunction

endpackage

// File: rtl/bcd_digit_counter.sv
// One BCD digit of the cascade: counts 0..MAX when enabled, wraps to 0.
module bcd_digit_counter
    import stopwatch_pkg::*;
#(
    parameter logic [3:0] MAX = DIGIT_MAX_9
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       en,
    output logic [3:0] q,
    output logic       at_max
);

    logic [3:0] q_r;

    // Digit register with synchronous clear and wrap at MAX
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_r <= 4'd0;
        end else if (clr) begin
            q_r <= 4'd0;
        end else if (en) begin
            q_r <= (q_r == MAX) ? 4'd0 : q_r + 4'd1;
        end else begin
            q_r <= q_r;
        end
    end

    assign q      = q_r;
    assign at_max = (q_r == MAX);

endmodule

// File: rtl/stopwatch_core.sv
// Stopwatch timekeeping: button edge detect, run/pause/lap FSM, tick prescaler,
// six-digit BCD cascade and lap snapshot feeding the display controller.
module stopwatch_core
    import stopwatch_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int TICK_HZ     = 100
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_stop_in,
    input  logic        lap_in,
    input  logic        clear_in,
    output logic [23:0] bcd_data_out,
    output logic        dp_out,
    output logic        running_out,
    output logic        lap_out,
    output logic        overflow_out
);

    localparam int DIV = tick_div(CLK_FREQ_HZ, TICK_HZ);
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

    logic [2:0]    btn_s, btn_q_r, evt_r;
    logic          ev_clr_s, ev_ss_s, ev_lap_s;
    state_t        state_r, state_next_s;
    logic [PW-1:0] presc_r;
    logic [23:0]   lap_r, live_s, bcd_s;
    logic          running_r, lap_flag_r, ovf_r;
    logic          counting_s, tick_s, sat_s, all_max_s;
    logic          zero_s, presc_zero_s, snap_s, set_ovf_s;
    logic [3:0]    digit_q_s [6];
    logic [5:0]    at_max_s;
    logic [5:0]    carry_s;

    assign btn_s = {clear_in, start_stop_in, lap_in};

    // Edge detect, with the event pulse registered once more before the FSM sees it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_q_r <= 3'b000;
            evt_r   <= 3'b000;
        end else begin
            btn_q_r <= btn_s;
            evt_r   <= btn_s & ~btn_q_r;
        end
    end

    // Same-cycle events: clear beats start/stop beats lap; losers are dropped
    assign ev_clr_s = evt_r[2];
    assign ev_ss_s  = evt_r[1] & ~evt_r[2];
    assign ev_lap_s = evt_r[0] & ~evt_r[1] & ~evt_r[2];

    assign counting_s = (state_r == ST_RUNNING) || (state_r == ST_LAP_HOLD);
    assign tick_s     = counting_s && (presc_r == PRESC_LAST);
    assign all_max_s  = &at_max_s;
    assign sat_s      = tick_s & all_max_s;
    assign carry_s[0] = tick_s & ~all_max_s;

    for (genvar i = 0; i < 6; i++) begin : g_digit
        localparam logic [3:0] DMAX = (i == 3 || i == 5) ? DIGIT_MAX_5 : DIGIT_MAX_9;
        bcd_digit_counter #(.MAX(DMAX)) u_digit (
            .clk    (clk),
            .rst_n  (rst_n),
            .clr    (zero_s),
            .en     (carry_s[i]),
            .q      (digit_q_s[i]),
            .at_max (at_max_s[i])
        );
        if (i < 5) begin : g_carry
            assign carry_s[i+1] = carry_s[i] & at_max_s[i];
        end
    end

    assign live_s[CS_ONES_LSB  +: 4] = digit_q_s[0];
    assign live_s[CS_TENS_LSB  +: 4] = digit_q_s[1];
    assign live_s[SEC_ONES_LSB +: 4] = digit_q_s[2];
    assign live_s[SEC_TENS_LSB +: 4] = digit_q_s[3];
    assign live_s[MIN_ONES_LSB +: 4] = digit_q_s[4];
    assign live_s[MIN_TENS_LSB +: 4] = digit_q_s[5];

    // Next-state and control strobes; saturation overrides any same-cycle button
    always_comb begin
        state_next_s = state_r;
        zero_s       = 1'b0;
        presc_zero_s = 1'b0;
        snap_s       = 1'b0;
        set_ovf_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (ev_ss_s) begin
                    state_next_s = ST_RUNNING;
                    presc_zero_s = 1'b1;
                end else if (ev_clr_s || ev_lap_s) begin
                    zero_s = 1'b1;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RUNNING: begin
                if (sat_s) begin
                    state_next_s = ST_PAUSED;
                    set_ovf_s    = 1'b1;
                end else if (ev_ss_s) begin
                    state_next_s = ST_PAUSED;
                end else if (ev_lap_s) begin
                    state_next_s = ST_LAP_HOLD;
                    snap_s       = 1'b1;
                end else begin
                    state_next_s = ST_RUNNING;
                end
            end
            ST_LAP_HOLD: begin
                if (sat_s) begin
                    state_next_s = ST_PAUSED;
                    set_ovf_s    = 1'b1;
                end else if (ev_ss_s) begin
                    state_next_s = ST_PAUSED;
                end else if (ev_lap_s) begin
                    state_next_s = ST_RUNNING;
                end else begin
                    state_next_s = ST_LAP_HOLD;
                end
            end
            ST_PAUSED: begin
                if (ev_clr_s) begin
                    state_next_s = ST_IDLE;
                    zero_s       = 1'b1;
                end else if (ev_ss_s && !ovf_r) begin
                    state_next_s = ST_RUNNING;
                end else begin
                    state_next_s = ST_PAUSED;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
                zero_s       = 1'b1;
            end
        endcase
    end

    // State, registered status flags and sticky overflow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            running_r  <= 1'b0;
            lap_flag_r <= 1'b0;
            ovf_r      <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            running_r  <= (state_next_s == ST_RUNNING) || (state_next_s == ST_LAP_HOLD);
            lap_flag_r <= (state_next_s == ST_LAP_HOLD);
            if (zero_s) begin
                ovf_r <= 1'b0;
            end else if (set_ovf_s) begin
                ovf_r <= 1'b1;
            end else begin
                ovf_r <= ovf_r;
            end
        end
    end

    // Prescaler holds while paused so a resumed run loses no partial tick
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_r <= '0;
        end else if (zero_s || presc_zero_s || tick_s) begin
            presc_r <= '0;
        end else if (counting_s) begin
            presc_r <= presc_r + PW'(1);
        end else begin
            presc_r <= presc_r;
        end
    end

    // Lap snapshot takes the pre-increment count on a coincident tick
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lap_r <= 24'h000000;
        end else if (snap_s) begin
            lap_r <= live_s;
        end else begin
            lap_r <= lap_r;
        end
    end

    // Display selects the frozen lap value only while holding a lap
    always_comb begin
        bcd_s = live_s;
        if (state_r == ST_LAP_HOLD) begin
            bcd_s = lap_r;
        end else begin
            bcd_s = live_s;
        end
    end

    assign bcd_data_out = bcd_s;
    assign dp_out       = running_r;
    assign running_out  = running_r;
    assign lap_out      = lap_flag_r;
    assign overflow_out = ovf_r;

endmodule

// File: tb/tb_stopwatch_core.sv
// Self-checking bench for stopwatch_core: hand table, directed corner cases,
// and random button traffic against a centisecond-count reference model.
module tb_stopwatch_core;

    localparam int CLK_HZ  = 1000;
    localparam int TICK_HZ = 100;
    localparam int DIV     = CLK_HZ / TICK_HZ;
    localparam int MAXCNT  = 59 * 6000 + 59 * 100 + 99;
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_LAP = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_stop_in = 1'b0, lap_in = 1'b0, clear_in = 1'b0;
    logic [23:0] bcd_data_out;
    logic        dp_out, running_out, lap_out, overflow_out;

    int n_pass = 0;
    int n_total = 0;

    // Reference model: whole count in centiseconds
    int   m_st, m_cnt, m_lapv, m_presc;
    logic m_ovf;
    logic m_pc, m_ps, m_pl, m_qc, m_qs, m_ql;

    typedef struct {
        logic ss, lap, clr;
        logic run, lapf, ovf;
        logic [23:0] bcd;
    } vec_t;
    vec_t tbl [19];

    stopwatch_core #(.CLK_FREQ_HZ(CLK_HZ), .TICK_HZ(TICK_HZ)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start_stop_in (start_stop_in),
        .lap_in        (lap_in),
        .clear_in      (clear_in),
        .bcd_data_out  (bcd_data_out),
        .dp_out        (dp_out),
        .running_out   (running_out),
        .lap_out       (lap_out),
        .overflow_out  (overflow_out)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] bcd_of(input int c);
        int cs, s, m;
        logic [23:0] r;
        cs = c % 100;
        s  = (c / 100) % 60;
        m  = c / 6000;
        r = {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), 4'(cs / 10), 4'(cs % 10)};
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_st = M_IDLE; m_cnt = 0; m_lapv = 0; m_presc = 0; m_ovf = 1'b0;
        m_pc = 1'b0; m_ps = 1'b0; m_pl = 1'b0; m_qc = 1'b0; m_qs = 1'b0; m_ql = 1'b0;
    endtask

    task automatic model_edge(input logic ss, input logic lp, input logic clr);
        logic e_c, e_s, e_l, counting, tick, sat;
        int old;
        e_c = m_pc;
        e_s = m_ps & ~m_pc;
        e_l = m_pl & ~m_pc & ~m_ps;
        m_pc = clr & ~m_qc; m_ps = ss & ~m_qs; m_pl = lp & ~m_ql;
        m_qc = clr; m_qs = ss; m_ql = lp;
        counting = (m_st == M_RUN) || (m_st == M_LAP);
        tick = counting && (m_presc == DIV - 1);
        if (counting) m_presc = tick ? 0 : m_presc + 1;
        sat = tick && (m_cnt == MAXCNT);
        old = m_cnt;
        if (tick && !sat) m_cnt = m_cnt + 1;
        case (m_st)
            M_IDLE: begin
                if (e_s) begin m_st = M_RUN; m_presc = 0; end
                else if (e_c || e_l) begin m_cnt = 0; m_presc = 0; m_ovf = 1'b0; end
            end
            M_RUN, M_LAP: begin
                if (sat) begin m_st = M_PAUSE; m_ovf = 1'b1; end
                else if (e_s) m_st = M_PAUSE;
                else if (e_l && m_st == M_RUN) begin m_st = M_LAP; m_lapv = old; end
                else if (e_l) m_st = M_RUN;
            end
            default: begin
                if (e_c) begin m_st = M_IDLE; m_cnt = 0; m_presc = 0; m_ovf = 1'b0; end
                else if (e_s && !m_ovf) m_st = M_RUN;
            end
        endcase
    endtask

    task automatic compare_model();
        logic run;
        run = (m_st == M_RUN) || (m_st == M_LAP);
        check("bcd", {8'h00, bcd_data_out}, {8'h00, (m_st == M_LAP) ? bcd_of(m_lapv) : bcd_of(m_cnt)});
        check("dp", {31'd0, dp_out}, {31'd0, run});
        check("running", {31'd0, running_out}, {31'd0, run});
        check("lap", {31'd0, lap_out}, {31'd0, (m_st == M_LAP)});
        check("overflow", {31'd0, overflow_out}, {31'd0, m_ovf});
    endtask

    // One clock with given button levels; inputs change 1 time unit after the edge
    task automatic cycle(input logic ss, input logic lp, input logic clr);
        start_stop_in = ss; lap_in = lp; clear_in = clr;
        @(posedge clk);
        model_edge(ss, lp, clr);
        #1;
        compare_model();
    endtask

    task automatic pulse(input logic ss, input logic lp, input logic clr);
        cycle(ss, lp, clr);
        cycle(1'b0, 1'b0, 1'b0);
    endtask

    task automatic run_until_cnt(input int target, input int budget);
        int n = 0;
        while (m_cnt != target && n < budget) begin cycle(1'b0, 1'b0, 1'b0); n++; end
        check("wait_count", {31'd0, (m_cnt == target)}, 32'd1);
    endtask

    task automatic do_reset();
        start_stop_in = 1'b0; lap_in = 1'b0; clear_in = 1'b0;
        rst_n = 1'b0;
        #2;
        check("rst_bcd", {8'h00, bcd_data_out}, 32'h0);
        check("rst_status", {28'd0, dp_out, running_out, lap_out, overflow_out}, 32'h0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 24'h000000};
        tbl[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 24'h000000};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 24'h000000};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 24'h000000};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 24'h000000};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 24'h000000};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 24'h000000};
        tbl[7]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 24'h000000};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 24'h000000};
        tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 24'h000000};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 24'h000000};
        tbl[11] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 24'h000000};
        tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 24'h000000};
        tbl[13] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 24'h000000};
        tbl[14] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 24'h000000};
        tbl[15] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 24'h000000};
        tbl[16] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 24'h000001};
        tbl[17] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 24'h000001};
        tbl[18] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 24'h000001};

        do_reset();
        for (int i = 0; i < 19; i++) begin
            start_stop_in = tbl[i].ss; lap_in = tbl[i].lap; clear_in = tbl[i].clr;
            @(posedge clk); #1;
            check($sformatf("tbl%0d_bcd", i), {8'h00, bcd_data_out}, {8'h00, tbl[i].bcd});
            check($sformatf("tbl%0d_status", i), {28'd0, dp_out, running_out, lap_out, overflow_out},
                  {28'd0, tbl[i].run, tbl[i].run, tbl[i].lapf, tbl[i].ovf});
        end

        // Idle after reset, then 1000 ticks of running
        do_reset();
        for (int i = 0; i < 100; i++) cycle(1'b0, 1'b0, 1'b0);
        check("idle_bcd", {8'h00, bcd_data_out}, 32'h0);
        pulse(1'b1, 1'b0, 1'b0);
        run_until_cnt(1000, 11000);
        check("ten_sec", {8'h00, bcd_data_out}, 32'h001000);
        check("ten_sec_dp", {31'd0, dp_out}, 32'd1);

        // Pause freezes the count, resume keeps the partial tick
        pulse(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b0);
        check("paused_frozen", {8'h00, bcd_data_out}, 32'h001000);
        pulse(1'b1, 1'b0, 1'b0);
        run_until_cnt(1001, 40);

        // Lap snapshot at 00:05.12
        pulse(1'b1, 1'b0, 1'b0);
        pulse(1'b0, 1'b0, 1'b1);
        pulse(1'b1, 1'b0, 1'b0);
        run_until_cnt(512, 6000);
        pulse(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 30; i++) cycle(1'b0, 1'b0, 1'b0);
        check("lap_hold_bcd", {8'h00, bcd_data_out}, 32'h000512);
        check("lap_hold_flag", {31'd0, lap_out}, 32'd1);
        pulse(1'b0, 1'b1, 1'b0);
        check("lap_release_flag", {31'd0, lap_out}, 32'd0);

        // Saturation at 59:59.99
        pulse(1'b1, 1'b0, 1'b0);
        dut.g_digit[5].u_digit.q_r <= 4'd5;
        dut.g_digit[4].u_digit.q_r <= 4'd9;
        dut.g_digit[3].u_digit.q_r <= 4'd5;
        dut.g_digit[2].u_digit.q_r <= 4'd9;
        dut.g_digit[1].u_digit.q_r <= 4'd9;
        dut.g_digit[0].u_digit.q_r <= 4'd8;
        m_cnt = MAXCNT - 1;
        pulse(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 40 && !m_ovf; i++) cycle(1'b0, 1'b0, 1'b0);
        check("sat_bcd", {8'h00, bcd_data_out}, 32'h595999);
        check("sat_ovf", {31'd0, overflow_out}, 32'd1);
        check("sat_paused", {31'd0, running_out}, 32'd0);
        pulse(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) cycle(1'b0, 1'b0, 1'b0);
        check("sat_restart_ignored", {8'h00, running_out, bcd_data_out[22:0]}, {8'h00, 24'h595999 & 24'h7fffff});
        pulse(1'b0, 1'b0, 1'b1);
        check("sat_clear_bcd", {8'h00, bcd_data_out}, 32'h0);
        check("sat_clear_ovf", {31'd0, overflow_out}, 32'd0);

        // clear + start_stop together while paused -> IDLE; clear while running ignored
        pulse(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 15; i++) cycle(1'b0, 1'b0, 1'b0);
        pulse(1'b1, 1'b0, 1'b0);
        pulse(1'b1, 1'b0, 1'b1);
        check("clr_ss_idle_run", {31'd0, running_out}, 32'd0);
        check("clr_ss_idle_bcd", {8'h00, bcd_data_out}, 32'h0);
        pulse(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 25; i++) cycle(1'b0, 1'b0, 1'b0);
        pulse(1'b0, 1'b0, 1'b1);
        check("clr_in_running", {31'd0, running_out}, 32'd1);

        // Random button traffic against the model
        for (int i = 0; i < 4000; i++) begin
            cycle(($urandom_range(0, 11) == 0) ? ~start_stop_in : start_stop_in,
                  ($urandom_range(0, 9) == 0) ? ~lap_in : lap_in,
                  ($urandom_range(0, 60) == 0) ? ~clear_in : clear_in);
        end

        // Asynchronous reset mid-count
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_bcd", {8'h00, bcd_data_out}, 32'h0);
        check("async_rst_status", {28'd0, dp_out, running_out, lap_out, overflow_out}, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
